v_ram: RTL and testbench

Vector register-file backing RAM: the responder on the VRAM port driven by the vector memory stage. It stores `DEPTH` words of `VLEN` bits and serves one registered read and one bit-masked write per cycle. After every reset it clears its contents with an internal initialisation sequencer and only then accepts requests. It sits directly below the vector memory stage in the vector datapath.

---
 rtl/v_ram_if.sv | 24 ++
 rtl/v_ram.sv | 50 +++++
 tb/tb_v_ram.sv | 138 +++++++++++++
 3 files changed

// File: rtl/v_ram_if.sv
// v_ram_if: VRAM port bundle (read/write requests from the master, data/valid/ready/err from the slave)
interface v_ram_if #(
  parameter int VLEN   = 512,
  parameter int ADDR_W = 64
);
  logic              r_ena;
  logic [ADDR_W-1:0] r_addr;
  logic [VLEN-1:0]   r_data;
  logic              r_valid;
  logic              w_ena;
  logic [ADDR_W-1:0] w_addr;
  logic [VLEN-1:0]   w_data;
  logic [VLEN-1:0]   w_mask;
  logic              ready;
  logic              err;
  modport master (
    output r_ena, r_addr, w_ena, w_addr, w_data, w_mask,
    input  r_data, r_valid, ready, err
  );
  modport slave (
    input  r_ena, r_addr, w_ena, w_addr, w_data, w_mask,
    output r_data, r_valid, ready, err
  );
endinterface

// File: rtl/v_ram.sv
// v_ram: self-clearing DEPTHxVLEN vector RAM; ports clk, async active-low rst, vram slave (registered read, bit-masked write-first write, ready, err)
module v_ram #(
  parameter int VLEN   = 512,
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 1024
) (
  input logic  clk,
  input logic  rst,
  v_ram_if.slave vram
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] cnt, cnt_nx, r_idx, w_idx;
  logic [VLEN-1:0] mem [DEPTH];
  logic [VLEN-1:0] w_word, r_word;
  logic run, r_oor, w_oor, w_go;
  assign run = state == RUN;
  assign r_idx = vram.r_addr[IDX_W-1:0];
  assign w_idx = vram.w_addr[IDX_W-1:0];
  assign r_oor = |vram.r_addr[ADDR_W-1:IDX_W];
  assign w_oor = |vram.w_addr[ADDR_W-1:IDX_W];
  assign w_go = run && vram.w_ena && !w_oor;
  assign w_word = (mem[w_idx] & ~vram.w_mask) | (vram.w_data & vram.w_mask);
  assign r_word = r_oor ? '0 : (w_go && w_idx == r_idx) ? w_word : mem[r_idx];
  assign vram.ready = run;
  always_comb begin
    state_nx = (!run && cnt == IDX_W'(DEPTH - 1)) ? RUN : state;
    cnt_nx = run ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
      cnt <= '0;
      vram.r_data <= '0;
      vram.r_valid <= 1'b0;
      vram.err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      vram.r_valid <= run && vram.r_ena;
      vram.err <= run && ((vram.r_ena && r_oor) || (vram.w_ena && w_oor));
      if (run && vram.r_ena) vram.r_data <= r_word;
    end
  end
  always_ff @(posedge clk) begin
    if (!run) mem[cnt] <= '0;
    else if (w_go) mem[w_idx] <= w_word;
  end
endmodule

// File: tb/tb_v_ram.sv
// tb_v_ram: directed self-checking bench for v_ram
module tb_v_ram;
  localparam int VLEN = 512;
  localparam int ADDR_W = 64;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [VLEN-1:0] ones, a5s, low_ff;
  v_ram_if #(.VLEN(VLEN), .ADDR_W(ADDR_W)) vif ();
  v_ram #(.VLEN(VLEN), .ADDR_W(ADDR_W), .DEPTH(1024)) dut (.clk(clk), .rst(rst), .vram(vif));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic re, input logic [ADDR_W-1:0] ra, input logic we,
                     input logic [ADDR_W-1:0] wa, input logic [VLEN-1:0] wd, input logic [VLEN-1:0] wm);
    vif.r_ena = re;
    vif.r_addr = ra;
    vif.w_ena = we;
    vif.w_addr = wa;
    vif.w_data = wd;
    vif.w_mask = wm;
  endtask
  task automatic idle();
    req(1'b0, '0, 1'b0, '0, '0, '0);
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!vif.ready && n < 2000) begin
      if (n == 600) req(1'b1, 64'h400, 1'b1, 64'd0, ones, ones);
      else idle();
      tick();
      n++;
      if (n == 601) begin
        check({tag, "_init_valid"}, VLEN'(vif.r_valid), '0);
        check({tag, "_init_err"}, VLEN'(vif.err), '0);
      end
    end
    idle();
    check({tag, "_init_edges"}, VLEN'(n), VLEN'(1024));
  endtask
  initial begin
    ones = '1;
    a5s = {64{8'hA5}};
    low_ff = VLEN'(8'hFF);
    idle();
    tick();
    tick();
    check("rst_data", vif.r_data, '0);
    check("rst_valid", VLEN'(vif.r_valid), '0);
    check("rst_ready", VLEN'(vif.ready), '0);
    check("rst_err", VLEN'(vif.err), '0);
    rst = 1'b1;
    wait_ready("first");
    req(1'b1, 64'd5, 1'b0, '0, '0, '0);
    tick();
    check("rd5_data", vif.r_data, '0);
    check("rd5_valid", VLEN'(vif.r_valid), VLEN'(1));
    idle();
    tick();
    check("rd5_valid_drop", VLEN'(vif.r_valid), '0);
    req(1'b1, 64'd0, 1'b0, '0, '0, '0);
    tick();
    check("init_write_ignored", vif.r_data, '0);
    req(1'b0, '0, 1'b1, 64'd3, ones, ones);
    tick();
    req(1'b0, '0, 1'b1, 64'd3, '0, low_ff);
    tick();
    req(1'b1, 64'd3, 1'b0, '0, '0, '0);
    tick();
    check("masked_write", vif.r_data, ~low_ff);
    idle();
    tick();
    check("hold_data", vif.r_data, ~low_ff);
    check("hold_valid", VLEN'(vif.r_valid), '0);
    req(1'b0, '0, 1'b1, 64'd3, '0, '0);
    tick();
    req(1'b1, 64'd3, 1'b0, '0, '0, '0);
    tick();
    check("zero_mask", vif.r_data, ~low_ff);
    req(1'b1, 64'd7, 1'b1, 64'd7, a5s, ones);
    tick();
    check("raw_data", vif.r_data, a5s);
    check("raw_valid", VLEN'(vif.r_valid), VLEN'(1));
    req(1'b1, 64'd7, 1'b1, 64'd8, ones, ones);
    tick();
    check("diff_idx_rd", vif.r_data, a5s);
    req(1'b1, 64'd8, 1'b0, '0, '0, '0);
    tick();
    check("b2b_rd8", vif.r_data, ones);
    check("b2b_valid", VLEN'(vif.r_valid), VLEN'(1));
    req(1'b1, 64'h400, 1'b1, 64'h1_0000_0000, ones, ones);
    tick();
    check("oor_err", VLEN'(vif.err), VLEN'(1));
    check("oor_valid", VLEN'(vif.r_valid), VLEN'(1));
    check("oor_data", vif.r_data, '0);
    req(1'b1, 64'd0, 1'b0, '0, '0, '0);
    tick();
    check("oor_err_pulse", VLEN'(vif.err), '0);
    check("oor_no_write", vif.r_data, '0);
    req(1'b0, '0, 1'b1, 64'h800, ones, ones);
    tick();
    check("oor_w_err", VLEN'(vif.err), VLEN'(1));
    check("oor_w_valid", VLEN'(vif.r_valid), '0);
    req(1'b1, 64'd3, 1'b1, 64'd9, VLEN'(16'h1234), ones);
    tick();
    check("pre_rst_data", vif.r_data, ~low_ff);
    req(1'b1, 64'd9, 1'b0, '0, '0, '0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_data", vif.r_data, '0);
    check("mid_rst_valid", VLEN'(vif.r_valid), '0);
    check("mid_rst_ready", VLEN'(vif.ready), '0);
    idle();
    tick();
    tick();
    check("mid_rst_hold", VLEN'(vif.r_valid), '0);
    rst = 1'b1;
    wait_ready("second");
    req(1'b1, 64'd9, 1'b0, '0, '0, '0);
    tick();
    check("rd9_cleared", vif.r_data, '0);
    check("rd9_valid", VLEN'(vif.r_valid), VLEN'(1));
    idle();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
